// File: rtl/muldiv_unit.sv
// muldiv_unit -- RV32M multiply/divide unit.
//
// Multiplies use iterative shift-add on 32-bit magnitudes. Divides use
// restoring division on magnitudes. Each iterative operation spends 32
// cycles in CALC and then one cycle in DONE, where ready pulses. A start
// in cycle 0 therefore gives ready in cycle 33.
//
// Optional build macro MULDIV_FAST_MUL_EN: the four multiplies are computed
// combinationally and go straight from the accepting state to DONE, so ready
// is high in cycle 1. Divides stay iterative. When the macro is undefined,
// all eight operations use the iterative path.
//
// Ports:
//   clk       in   clock; all state changes on its rising edge
//   rst       in   asynchronous active-high reset
//   MD_start  in   start request; sampled only in IDLE or DONE
//   funct3    in   [2:0]  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                         100 DIV, 101 DIVU, 110 REM, 111 REMU
//   A, B      in   [31:0] operands rs1, rs2
//   result    out  [31:0] held from entry to DONE until the next result
//   ready     out  one-cycle completion pulse (high in DONE)
//   busy      out  high exactly in CALC
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        MD_start,
   input  logic [2:0]  funct3,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] result,
   output logic        ready,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t      state_reg, state_next;
   logic        accept;
   logic        fast_go;
   logic        last_iter;

   logic [4:0]  cnt_reg;
   logic [2:0]  op_reg;
   logic [31:0] a_reg;
   logic        sign_q_reg;      // product / quotient negation
   logic        sign_r_reg;      // remainder negation (dividend sign)
   logic        div_zero_reg;
   logic [63:0] acc_reg;
   logic [63:0] mcand_reg;
   logic [31:0] mplier_reg;
   logic [31:0] rem_reg;
   logic [31:0] quo_reg;
   logic [31:0] divisor_reg;
   logic [31:0] result_reg;

   logic        in_a_signed, in_b_signed;
   logic        in_a_neg, in_b_neg;
   logic [31:0] in_a_mag, in_b_mag;

   logic [63:0] acc_next;
   logic [32:0] shifted, diff;
   logic [31:0] rem_next, quo_next;
   logic [63:0] prod_final;
   logic [31:0] quo_final, rem_final, calc_result;

   logic        result_load;
   logic [31:0] result_value;

   // Operand signedness and magnitudes, taken from the live inputs and
   // latched on accept.
   assign in_a_signed = funct3[2] ? ~funct3[0] : ((funct3 == 3'b001) || (funct3 == 3'b010));
   assign in_b_signed = funct3[2] ? ~funct3[0] : (funct3 == 3'b001);
   assign in_a_neg    = in_a_signed & A[31];
   assign in_b_neg    = in_b_signed & B[31];
   assign in_a_mag    = in_a_neg ? (~A + 32'd1) : A;
   assign in_b_mag    = in_b_neg ? (~B + 32'd1) : B;

`ifdef MULDIV_FAST_MUL_EN
   logic [63:0] fast_mag, fast_prod;
   logic [31:0] fast_result;

   assign fast_mag    = {32'd0, in_a_mag} * {32'd0, in_b_mag};
   assign fast_prod   = (in_a_neg ^ in_b_neg) ? (~fast_mag + 64'd1) : fast_mag;
   assign fast_result = (funct3 == 3'b000) ? fast_prod[31:0] : fast_prod[63:32];
   assign fast_go     = ~funct3[2];
`else
   assign fast_go     = 1'b0;
`endif

   // FSM: state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM: next state and outputs.
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      ready      = 1'b0;
      busy       = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            ready = (state_reg == DONE);
            if (MD_start) begin
               accept     = 1'b1;
               state_next = fast_go ? DONE : CALC;
            end else begin
               state_next = IDLE;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (cnt_reg == 5'd31) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign last_iter = (state_reg == CALC) && (cnt_reg == 5'd31);

   // One iteration step of each engine.
   always_comb begin
      acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
      shifted  = {rem_reg, quo_reg[31]};
      diff     = shifted - {1'b0, divisor_reg};
      // Since the partial remainder is below the divisor, bit 32 of diff is
      // a clean borrow flag.
      if (!diff[32]) begin
         rem_next = diff[31:0];
         quo_next = {quo_reg[30:0], 1'b1};
      end else begin
         rem_next = shifted[31:0];
         quo_next = {quo_reg[30:0], 1'b0};
      end
   end

   // Final sign fix-up and result select, using the last iteration's outputs.
   // Signed overflow (0x80000000 / -1) needs no special case: the magnitude
   // quotient 0x80000000 negates to itself and the remainder is 0.
   always_comb begin
      prod_final = sign_q_reg ? (~acc_next + 64'd1) : acc_next;
      quo_final  = sign_q_reg ? (~quo_next + 32'd1) : quo_next;
      rem_final  = sign_r_reg ? (~rem_next + 32'd1) : rem_next;
      case (op_reg)
         3'b000:                 calc_result = prod_final[31:0];
         3'b001, 3'b010, 3'b011: calc_result = prod_final[63:32];
         3'b100, 3'b101:         calc_result = div_zero_reg ? 32'hFFFF_FFFF : quo_final;
         default:                calc_result = div_zero_reg ? a_reg : rem_final;
      endcase
   end

   always_comb begin
      result_load  = last_iter;
      result_value = calc_result;
`ifdef MULDIV_FAST_MUL_EN
      if (accept && fast_go) begin
         result_load  = 1'b1;
         result_value = fast_result;
      end
`endif
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg      <= '0;
         op_reg       <= '0;
         a_reg        <= '0;
         sign_q_reg   <= 1'b0;
         sign_r_reg   <= 1'b0;
         div_zero_reg <= 1'b0;
         acc_reg      <= '0;
         mcand_reg    <= '0;
         mplier_reg   <= '0;
         rem_reg      <= '0;
         quo_reg      <= '0;
         divisor_reg  <= '0;
         result_reg   <= '0;
      end else begin
         if (accept) begin
            cnt_reg      <= '0;
            op_reg       <= funct3;
            a_reg        <= A;
            sign_q_reg   <= in_a_neg ^ in_b_neg;
            sign_r_reg   <= in_a_neg;
            div_zero_reg <= (B == 32'd0);
            acc_reg      <= '0;
            mcand_reg    <= {32'd0, in_a_mag};
            mplier_reg   <= in_b_mag;
            rem_reg      <= '0;
            quo_reg      <= in_a_mag;
            divisor_reg  <= in_b_mag;
         end else if (state_reg == CALC) begin
            cnt_reg    <= cnt_reg + 5'd1;
            acc_reg    <= acc_next;
            mcand_reg  <= {mcand_reg[62:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[31:1]};
            rem_reg    <= rem_next;
            quo_reg    <= quo_next;
         end
         if (result_load) begin
            result_reg <= result_value;
         end
      end
   end

   assign result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- self-checking bench for muldiv_unit.
// The reference model is plain 64-bit and signed integer arithmetic on the
// RV32M definitions. It is followed by directed corner cases, start-handling
// and reset scenarios, and randomized operations.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        MD_start;
   logic [2:0]  funct3;
   logic [31:0] A, B;
   logic [31:0] result;
   logic        ready, busy;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_unit dut (
      .clk      (clk),
      .rst      (rst),
      .MD_start (MD_start),
      .funct3   (funct3),
      .A        (A),
      .B        (B),
      .result   (result),
      .ready    (ready),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] xa, xb, p;
      int sa, sb;
      sa = a;
      sb = b;
      xa = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
      xb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = xa * xb;
      case (f3)
         3'd0: return p[31:0];
         3'd1, 3'd2, 3'd3: return p[63:32];
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return sa / sb;
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return sa % sb;
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int exp_latency(input logic [2:0] f3);
`ifdef MULDIV_FAST_MUL_EN
      if (!f3[2]) return 1;
`endif
      return 33;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Starts an operation in the current cycle (cycle 0), scrambles the inputs
   // while it runs, and checks latency, busy span and result. With gap set,
   // it steps one more cycle to confirm the ready pulse ends and the result holds.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input bit gap);
      int cyc;
      int busy_cnt;
      int lat;
      logic [31:0] exp;
      exp      = ref_model(f3, a, b);
      lat      = exp_latency(f3);
      MD_start = 1'b1;
      funct3   = f3;
      A        = a;
      B        = b;
      cyc      = 0;
      busy_cnt = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
         MD_start = 1'b0;
         A        = $urandom;
         B        = $urandom;
         funct3   = 3'($urandom);
         if (busy) busy_cnt++;
      end while (!ready && cyc < 40);
      $display("op %s f3=%0d A=%08h B=%08h result=%08h expect=%08h latency=%0d",
               tag, f3, a, b, result, exp, cyc);
      check_val({tag, "_latency"}, cyc, lat);
      check_val({tag, "_busy_cycles"}, busy_cnt, (lat == 1) ? 0 : 32);
      check_val({tag, "_result"}, result, exp);
      if (gap) begin
         @(posedge clk);
         #1;
         check_val({tag, "_ready_pulse"}, ready, 1'b0);
         check_val({tag, "_result_hold"}, result, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int ready_cyc;
      int busy_cnt;
      logic [31:0] exp;

      rst      = 1'b1;
      MD_start = 1'b0;
      funct3   = 3'd0;
      A        = 32'd0;
      B        = 32'd0;
      #1;
      check_val("reset_result", result, 32'd0);
      check_val("reset_ready", ready, 1'b0);
      check_val("reset_busy", busy, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed cases
      run_op("mul_7_m3",   3'b000, 32'd7, 32'hFFFF_FFFD, 1);
      check_val("mul_7_m3_value", result, 32'hFFFF_FFEB);
      run_op("mulhu_ff",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      check_val("mulhu_ff_value", result, 32'hFFFF_FFFE);
      run_op("mulh_ff",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      check_val("mulh_ff_value", result, 32'h0000_0000);
      run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 1);
      check_val("div_m7_2_value", result, 32'hFFFF_FFFD);
      run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 1);
      check_val("rem_m7_2_value", result, 32'hFFFF_FFFF);
      run_op("divu_m7_2",  3'b101, 32'hFFFF_FFF9, 32'd2, 1);
      check_val("divu_m7_2_value", result, 32'h7FFF_FFFC);
      run_op("divu_5_0",   3'b101, 32'd5, 32'd0, 1);
      check_val("divu_5_0_value", result, 32'hFFFF_FFFF);
      run_op("remu_5_0",   3'b111, 32'd5, 32'd0, 1);
      check_val("remu_5_0_value", result, 32'd5);
      run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1);
      check_val("div_ovf_value", result, 32'h8000_0000);
      run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1);
      check_val("rem_ovf_value", result, 32'd0);
      run_op("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF, 32'd2, 1);

      // MD_start held high through CALC while A changes
      exp       = ref_model(3'b100, 32'd1000, 32'd7);
      MD_start  = 1'b1;
      funct3    = 3'b100;
      A         = 32'd1000;
      B         = 32'd7;
      pulses    = 0;
      ready_cyc = 0;
      busy_cnt  = 0;
      for (int c = 1; c <= 45; c++) begin
         @(posedge clk);
         #1;
         if (busy) busy_cnt++;
         if (ready) begin
            pulses++;
            ready_cyc = c;
            check_val("hold_start_result", result, exp);
         end
         MD_start = (c < 33);
         A        = $urandom;
      end
      $display("op hold_start result=%08h pulses=%0d ready_cycle=%0d", result, pulses, ready_cyc);
      check_val("hold_start_pulses", pulses, 1);
      check_val("hold_start_ready_cycle", ready_cyc, 33);
      check_val("hold_start_busy_cycles", busy_cnt, 32);
      check_val("hold_start_idle_hold", result, exp);

      // Start accepted in the DONE cycle: back-to-back operations
      run_op("b2b_first",  3'b101, 32'd123456, 32'd10, 0);
      run_op("b2b_second", 3'b110, 32'hFFFF_FC00, 32'd7, 1);

      // Reset in CALC cycle 10
      run_op("pre_reset", 3'b000, 32'd7, 32'hFFFF_FFFD, 1);
      MD_start = 1'b1;
      funct3   = 3'b100;
      A        = 32'd100;
      B        = 32'd7;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         MD_start = 1'b0;
      end
      check_val("pre_reset_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      check_val("mid_reset_busy", busy, 1'b0);
      check_val("mid_reset_ready", ready, 1'b0);
      check_val("mid_reset_result", result, 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ready) pulses++;
      end
      $display("op reset_abort result=%08h ready_pulses=%0d", result, pulses);
      check_val("post_reset_no_ready", pulses, 0);
      check_val("post_reset_result", result, 32'd0);
      run_op("first_after_reset", 3'b100, 32'd100, 32'd7, 1);

      // Randomized operations, including back-to-back starts in DONE
      for (int i = 0; i < 50; i++) begin
         run_op("rand", 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                bit'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
